// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch path in front of InstructionMemory.
// The fetch queue entry pairs each captured word with the PC it was read from.
package imem_pkg;

  localparam int MEM_BYTES_DEF = 512;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // A redirect is usable only if word aligned and inside the fetch window.
  function automatic logic isLegalTarget(input logic [31:0] target, input logic [31:0] lastPc);
    return (target[1:0] == 2'b00) && (target <= lastPc);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory, control and decode-handshake signals of the fetch unit.
// master is the fetch unit itself; slave is the surrounding datapath (memory + decode).
interface instruction_fetch_unit_if;
  import imem_pkg::*;

  logic                start;
  logic                redirectValid;
  logic [31:0]         redirectTarget;
  logic [31:0]         instructionAddress;
  logic [INSTR_W-1:0]  instructionIn;
  logic                fetchValid;
  logic                fetchReady;
  logic [INSTR_W-1:0]  fetchInstruction;
  logic [31:0]         fetchPc;
  logic                halted;
  logic                fault;

  modport master (
    input  start, redirectValid, redirectTarget, instructionIn, fetchReady,
    output instructionAddress, fetchValid, fetchInstruction, fetchPc, halted, fault
  );

  modport slave (
    output start, redirectValid, redirectTarget, instructionIn, fetchReady,
    input  instructionAddress, fetchValid, fetchInstruction, fetchPc, halted, fault
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Synchronous FIFO of fetch entries; flush wins over push and pop.
// Head reads as zero while empty so the decode side never sees stale data.
module fetch_queue
  import imem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t pushEntry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  fetch_entry_t     slots [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_DEPTH);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign head   = empty ? '{pc: 32'h0, instr: NOP} : slots[rdPtr];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
      if (doPush && !doPop) begin
        count <= count + CNT_ONE;
      end else if (doPop && !doPush) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // When full with a simultaneous pop, wrPtr equals rdPtr; the head is read before this write lands.
  always_ff @(posedge clock) begin
    if (doPush && !flush) slots[wrPtr] <= pushEntry;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: owns the PC, reads the combinational InstructionMemory and queues {PC, word} for decode.
// Branch/jump redirects flush the queue; an illegal target locks the unit in FAULT until reset.
//
//   state | meaning
//   IDLE  | waiting for start, nothing issued
//   RUN   | issuing one fetch per edge while the queue has room (or is popping)
//   HALT  | PC ran past the memory window; queue drains, legal redirect resumes
//   FAULT | illegal redirect seen; queue flushed, sticky until reset
module instruction_fetch_unit
  import imem_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = MEM_BYTES_DEF,
  parameter int          DEPTH     = 2
) (
  input logic                       clock,
  input logic                       resetN,
  instruction_fetch_unit_if.master  bus
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pcNext;
  logic         haltedReg;
  logic         faultReg;
  logic         qFull;
  logic         qEmpty;
  logic         qPush;
  logic         qPop;
  logic         qFlush;
  logic         redirectTake;
  logic         redirectLegal;
  fetch_entry_t pushEntry;
  fetch_entry_t headEntry;

  assign pcNext        = pc + 32'd4;
  assign redirectTake  = bus.redirectValid && ((state == RUN) || (state == HALT));
  assign redirectLegal = isLegalTarget(bus.redirectTarget, LAST_PC);

  // Any redirect in RUN blocks the push, legal or not: the word at the old PC is dead either way.
  assign qFlush    = redirectTake;
  assign qPop      = !qEmpty && bus.fetchReady;
  assign qPush     = (state == RUN) && !bus.redirectValid && (!qFull || qPop);
  assign pushEntry = '{pc: pc, instr: bus.instructionIn};

  fetch_queue #(
    .DEPTH(DEPTH)
  ) queue (
    .clock    (clock),
    .resetN   (resetN),
    .push     (qPush),
    .pop      (qPop),
    .flush    (qFlush),
    .pushEntry(pushEntry),
    .full     (qFull),
    .empty    (qEmpty),
    .head     (headEntry)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      haltedReg <= 1'b0;
      faultReg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) state <= RUN;
        end
        RUN, HALT: begin
          if (redirectTake) begin
            haltedReg <= 1'b0;
            if (redirectLegal) begin
              pc    <= bus.redirectTarget;
              state <= RUN;
            end else begin
              state    <= FAULT;
              faultReg <= 1'b1;
            end
          end else if (qPush) begin
            pc <= pcNext;
            if (pcNext > LAST_PC) begin
              state     <= HALT;
              haltedReg <= 1'b1;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.instructionAddress = pc;
  assign bus.fetchValid         = !qEmpty;
  assign bus.fetchInstruction   = headEntry.instr;
  assign bus.fetchPc            = headEntry.pc;
  assign bus.halted             = haltedReg;
  assign bus.fault              = faultReg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboarded bench for instruction_fetch_unit with a small behavioural InstructionMemory.
module tb_instruction_fetch_unit;
  import imem_pkg::*;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  int   total = 0;
  int   bad = 0;
  fetch_entry_t expQ[$];

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_PC (32'h0),
    .MEM_BYTES(512),
    .DEPTH    (2)
  ) dut (
    .clock (clock),
    .resetN(resetN),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h2108_0008;
      32'h0000_0014: return 32'hAC08_0000;
      default:       return {16'h8C00, addr[15:0]} ^ 32'h0000_5A00;
    endcase
  endfunction

  always_comb bus.instructionIn = memWord(bus.instructionAddress);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic applyReset();
    bus.start = 1'b0;
    bus.redirectValid = 1'b0;
    bus.redirectTarget = 32'h0;
    bus.fetchReady = 1'b0;
    resetN = 1'b0;
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    expQ.delete();
  endtask

  task automatic startFetch();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic pushExp(input logic [31:0] firstPc, input int n);
    for (int i = 0; i < n; i++) begin
      expQ.push_back('{pc: firstPc + 32'(4 * i), instr: memWord(firstPc + 32'(4 * i))});
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.redirectValid = 1'b0;
    bus.redirectTarget = 32'h0;
    bus.fetchReady = 1'b1;
    resetN = 1'b0;
    @(negedge clock);
    total += 6;
    if (bus.fetchValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.fetchValid); end
    if (bus.fetchInstruction !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", bus.fetchInstruction); end
    if (bus.fetchPc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", bus.fetchPc); end
    if (bus.halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    if (bus.fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
    if (bus.instructionAddress !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus.instructionAddress); end
    resetN = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if (bus.fetchValid !== 1'b0 || bus.instructionAddress !== 32'h0) begin
      bad++; $display("FAIL idle_no_fetch: valid=%b addr=%h want 0/0", bus.fetchValid, bus.instructionAddress);
    end
  endtask

  task automatic test_stream();
    fetch_entry_t want;
    int got = 0;
    int firstC = -1;
    int lastC = -1;
    applyReset();
    bus.fetchReady = 1'b1;
    startFetch();
    pushExp(32'h0, 8);
    for (int c = 0; c < 20 && got < 8; c++) begin
      if (bus.fetchValid && bus.fetchReady) begin
        want = expQ.pop_front();
        total++;
        if (bus.fetchPc !== want.pc || bus.fetchInstruction !== want.instr) begin
          bad++; $display("FAIL stream_entry: got pc=%h instr=%h want pc=%h instr=%h", bus.fetchPc, bus.fetchInstruction, want.pc, want.instr);
        end
        if (firstC < 0) firstC = c;
        lastC = c;
        got++;
      end
      @(negedge clock);
    end
    total += 2;
    if (got != 8) begin bad++; $display("FAIL stream_count: got %0d want 8", got); end
    if (firstC != 1 || lastC - firstC != 7) begin
      bad++; $display("FAIL stream_timing: first=%0d span=%0d want 1/7", firstC, lastC - firstC);
    end
  endtask

  task automatic test_backpressure();
    fetch_entry_t want;
    int got = 0;
    int firstC = -1;
    int lastC = -1;
    applyReset();
    bus.fetchReady = 1'b0;
    startFetch();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      total++;
      if (bus.fetchValid !== 1'b1 || bus.fetchPc !== 32'h0 || bus.fetchInstruction !== 32'h2108_0008) begin
        bad++; $display("FAIL bp_head_stable: valid=%b pc=%h instr=%h want 1/0/21080008", bus.fetchValid, bus.fetchPc, bus.fetchInstruction);
      end
    end
    total++;
    if (bus.instructionAddress !== 32'h8) begin bad++; $display("FAIL bp_pc_hold: got %h want 8", bus.instructionAddress); end
    pushExp(32'h0, 4);
    bus.fetchReady = 1'b1;
    for (int c = 0; c < 12 && got < 4; c++) begin
      if (bus.fetchValid && bus.fetchReady) begin
        want = expQ.pop_front();
        total++;
        if (bus.fetchPc !== want.pc || bus.fetchInstruction !== want.instr) begin
          bad++; $display("FAIL bp_entry: got pc=%h instr=%h want pc=%h instr=%h", bus.fetchPc, bus.fetchInstruction, want.pc, want.instr);
        end
        if (firstC < 0) firstC = c;
        lastC = c;
        got++;
      end
      @(negedge clock);
    end
    total++;
    if (got != 4 || firstC != 0 || lastC - firstC != 3) begin
      bad++; $display("FAIL bp_release: got=%0d first=%0d span=%0d want 4/0/3", got, firstC, lastC - firstC);
    end
  endtask

  task automatic test_redirect();
    fetch_entry_t want;
    int got = 0;
    int firstC = -1;
    applyReset();
    bus.fetchReady = 1'b0;
    startFetch();
    repeat (4) @(negedge clock);
    bus.redirectValid = 1'b1;
    bus.redirectTarget = 32'h14;
    @(negedge clock);
    bus.redirectValid = 1'b0;
    total++;
    if (bus.fetchValid !== 1'b0 || bus.instructionAddress !== 32'h14) begin
      bad++; $display("FAIL redir_flush: valid=%b addr=%h want 0/14", bus.fetchValid, bus.instructionAddress);
    end
    pushExp(32'h14, 3);
    bus.fetchReady = 1'b1;
    for (int c = 0; c < 12 && got < 3; c++) begin
      if (bus.fetchValid && bus.fetchReady) begin
        want = expQ.pop_front();
        total++;
        if (bus.fetchPc !== want.pc || bus.fetchInstruction !== want.instr) begin
          bad++; $display("FAIL redir_entry: got pc=%h instr=%h want pc=%h instr=%h", bus.fetchPc, bus.fetchInstruction, want.pc, want.instr);
        end
        if (firstC < 0) firstC = c;
        got++;
      end
      @(negedge clock);
    end
    total++;
    if (got != 3 || firstC != 1) begin bad++; $display("FAIL redir_timing: got=%0d first=%0d want 3/1", got, firstC); end
  endtask

  task automatic test_halt();
    fetch_entry_t want;
    int got = 0;
    logic [31:0] lastPc = 32'hFFFF_FFFF;
    applyReset();
    bus.fetchReady = 1'b1;
    startFetch();
    pushExp(32'h0, 128);
    for (int c = 0; c < 300 && got < 128; c++) begin
      if (bus.fetchValid && bus.fetchReady) begin
        want = expQ.pop_front();
        total++;
        if (bus.fetchPc !== want.pc || bus.fetchInstruction !== want.instr) begin
          bad++; $display("FAIL halt_entry: got pc=%h instr=%h want pc=%h instr=%h", bus.fetchPc, bus.fetchInstruction, want.pc, want.instr);
        end
        lastPc = bus.fetchPc;
        got++;
      end
      @(negedge clock);
    end
    total += 2;
    if (got != 128 || lastPc !== 32'h1FC) begin bad++; $display("FAIL halt_last: got=%0d lastPc=%h want 128/1fc", got, lastPc); end
    if (bus.halted !== 1'b1) begin bad++; $display("FAIL halt_flag: got %b want 1", bus.halted); end
    repeat (3) begin
      total++;
      if (bus.fetchValid !== 1'b0) begin bad++; $display("FAIL halt_drained: valid=%b want 0", bus.fetchValid); end
      @(negedge clock);
    end
    bus.redirectValid = 1'b1;
    bus.redirectTarget = 32'h0;
    @(negedge clock);
    bus.redirectValid = 1'b0;
    total++;
    if (bus.halted !== 1'b0) begin bad++; $display("FAIL halt_resume_flag: got %b want 0", bus.halted); end
    got = 0;
    pushExp(32'h0, 2);
    for (int c = 0; c < 10 && got < 2; c++) begin
      if (bus.fetchValid && bus.fetchReady) begin
        want = expQ.pop_front();
        total++;
        if (bus.fetchPc !== want.pc || bus.fetchInstruction !== want.instr) begin
          bad++; $display("FAIL halt_resume_entry: got pc=%h instr=%h want pc=%h instr=%h", bus.fetchPc, bus.fetchInstruction, want.pc, want.instr);
        end
        got++;
      end
      @(negedge clock);
    end
    total++;
    if (got != 2) begin bad++; $display("FAIL halt_resume_count: got %0d want 2", got); end
  endtask

  task automatic test_last_target();
    fetch_entry_t want;
    int got = 0;
    applyReset();
    bus.fetchReady = 1'b0;
    startFetch();
    repeat (4) @(negedge clock);
    bus.redirectValid = 1'b1;
    bus.redirectTarget = 32'h1FC;
    @(negedge clock);
    bus.redirectValid = 1'b0;
    total++;
    if (bus.fault !== 1'b0 || bus.instructionAddress !== 32'h1FC) begin
      bad++; $display("FAIL edge_target: fault=%b addr=%h want 0/1fc", bus.fault, bus.instructionAddress);
    end
    pushExp(32'h1FC, 1);
    bus.fetchReady = 1'b1;
    for (int c = 0; c < 8 && got < 1; c++) begin
      if (bus.fetchValid && bus.fetchReady) begin
        want = expQ.pop_front();
        total++;
        if (bus.fetchPc !== want.pc || bus.fetchInstruction !== want.instr) begin
          bad++; $display("FAIL edge_entry: got pc=%h instr=%h want pc=%h instr=%h", bus.fetchPc, bus.fetchInstruction, want.pc, want.instr);
        end
        got++;
      end
      @(negedge clock);
    end
    total++;
    if (got != 1 || bus.halted !== 1'b1 || bus.fetchValid !== 1'b0) begin
      bad++; $display("FAIL edge_halt: got=%0d halted=%b valid=%b want 1/1/0", got, bus.halted, bus.fetchValid);
    end
  endtask

  task automatic test_fault();
    logic [31:0] targets [2];
    targets[0] = 32'h6;
    targets[1] = 32'h200;
    for (int t = 0; t < 2; t++) begin
      applyReset();
      bus.fetchReady = 1'b0;
      startFetch();
      repeat (4) @(negedge clock);
      bus.redirectValid = 1'b1;
      bus.redirectTarget = targets[t];
      @(negedge clock);
      bus.redirectValid = 1'b0;
      total++;
      if (bus.fault !== 1'b1 || bus.fetchValid !== 1'b0 || bus.halted !== 1'b0 || bus.instructionAddress !== 32'h8) begin
        bad++; $display("FAIL fault_entry target=%h: fault=%b valid=%b halted=%b addr=%h want 1/0/0/8",
                        targets[t], bus.fault, bus.fetchValid, bus.halted, bus.instructionAddress);
      end
      bus.fetchReady = 1'b1;
      bus.redirectValid = 1'b1;
      bus.redirectTarget = 32'h0;
      @(negedge clock);
      bus.redirectValid = 1'b0;
      repeat (4) begin
        total++;
        if (bus.fault !== 1'b1 || bus.fetchValid !== 1'b0 || bus.instructionAddress !== 32'h8) begin
          bad++; $display("FAIL fault_sticky target=%h: fault=%b valid=%b addr=%h want 1/0/8",
                          targets[t], bus.fault, bus.fetchValid, bus.instructionAddress);
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_reset_mid();
    fetch_entry_t want;
    int got = 0;
    applyReset();
    bus.fetchReady = 1'b0;
    startFetch();
    repeat (4) @(negedge clock);
    resetN = 1'b0;
    #1;
    total++;
    if (bus.fetchValid !== 1'b0 || bus.instructionAddress !== 32'h0 || bus.fetchPc !== 32'h0) begin
      bad++; $display("FAIL midreset_async: valid=%b addr=%h pc=%h want 0/0/0", bus.fetchValid, bus.instructionAddress, bus.fetchPc);
    end
    @(negedge clock);
    resetN = 1'b1;
    bus.fetchReady = 1'b1;
    repeat (4) begin
      @(negedge clock);
      total++;
      if (bus.fetchValid !== 1'b0 || bus.instructionAddress !== 32'h0) begin
        bad++; $display("FAIL midreset_idle: valid=%b addr=%h want 0/0", bus.fetchValid, bus.instructionAddress);
      end
    end
    expQ.delete();
    startFetch();
    pushExp(32'h0, 2);
    for (int c = 0; c < 8 && got < 2; c++) begin
      if (bus.fetchValid && bus.fetchReady) begin
        want = expQ.pop_front();
        total++;
        if (bus.fetchPc !== want.pc || bus.fetchInstruction !== want.instr) begin
          bad++; $display("FAIL midreset_entry: got pc=%h instr=%h want pc=%h instr=%h", bus.fetchPc, bus.fetchInstruction, want.pc, want.instr);
        end
        got++;
      end
      @(negedge clock);
    end
    total++;
    if (got != 2) begin bad++; $display("FAIL midreset_count: got %0d want 2", got); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.redirectValid = 1'b0;
    bus.redirectTarget = 32'h0;
    bus.fetchReady = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_last_target();
    test_fault();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
